regfile_write_arbiter: RTL and testbench

Shares the register file's single write port (RegWrite / writeRegister / writeData) between the ALU writeback path and the load-return path. The ALU has fixed priority and cannot be back-pressured. Load results are held in a small in-order queue with a valid/ready handshake. The block preserves write-after-write order by cancelling queued load writes that a younger ALU write supersedes, and it exports a pending-register bitmap that upstream hazard logic uses for stalls.

---
 rtl/regfile_write_arbiter_if.sv | 38 +++
 rtl/regfile_write_arbiter.sv | 143 ++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_write_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_write_arbiter_if
//  Description : Bundle of the ALU writeback, load-return handshake and
//                register-file write-port signals of regfile_write_arbiter.
//                master : producer side (ALU/load sources, sees write port)
//                slave  : arbiter side
//  Ports       : alu_valid/alu_rd/alu_data      ALU result
//                mem_valid/mem_rd/mem_data      load result offer
//                mem_ready                      load accepted when valid&&ready
//                RegWrite/writeRegister/writeData  registered write port
//                pending                        live queued-load bitmap
//  Revision    : 1.0 - initial release
// ============================================================================
interface regfile_write_arbiter_if;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        mem_valid;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic        RegWrite;
    logic [4:0]  writeRegister;
    logic [31:0] writeData;
    logic [31:0] pending;

    modport master (
        output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
        input  mem_ready, RegWrite, writeRegister, writeData, pending
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
        output mem_ready, RegWrite, writeRegister, writeData, pending
    );
endinterface
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_write_arbiter
//  Description : Shares the single register-file write port between the ALU
//                writeback path (fixed priority, never stalled) and an
//                in-order load-return queue. Younger ALU writes cancel queued
//                loads to the same register so write-after-write order holds.
//  Ports       : clk    rising-edge clock
//                reset  synchronous active-high reset
//                bus    regfile_write_arbiter_if.slave (see interface file)
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    regfile_write_arbiter_if.slave  bus
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_ONE  = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0] c_LAST = c_PTR_W'(DEPTH - 1);

    // Queue storage
    logic [4:0]         r_q_rd   [DEPTH];
    logic [31:0]        r_q_data [DEPTH];
    logic [DEPTH-1:0]   r_q_live;
    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [c_CNT_W-1:0] r_count;

    // Write port registers
    logic               r_we;
    logic [4:0]         r_wr;
    logic [31:0]        r_wd;

    logic               w_kill;
    logic               w_mem_ready;
    logic               w_accept;
    logic               w_load_ok;
    logic               w_empty;
    logic               w_head_live;
    logic               w_pop;
    logic               w_bypass;
    logic               w_push;
    logic [DEPTH-1:0]   w_live_after;
    logic [31:0]        w_pending;

    assign w_kill      = bus.alu_valid && (bus.alu_rd != 5'd0);
    assign w_mem_ready = (r_count < c_FULL) && !reset;
    assign w_accept    = bus.mem_valid && w_mem_ready;
    // A load colliding with a same-cycle ALU write is the older one, so it is
    // superseded immediately; rd 0 loads complete the handshake and vanish.
    assign w_load_ok   = w_accept && (bus.mem_rd != 5'd0) &&
                         !(w_kill && (bus.mem_rd == bus.alu_rd));

    // Live bits as they stand after this cycle's kill.
    always_comb begin
        w_live_after = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_live_after[i] = r_q_live[i] &&
                              !(w_kill && (r_q_rd[i] == bus.alu_rd));
        end
    end

    assign w_empty     = (r_count == '0);
    assign w_head_live = !w_empty && w_live_after[r_head];
    // Head leaves when it is written (no ALU kill) or when it is dead; dead
    // entries never occupy the write port.
    assign w_pop       = !w_empty && (!w_head_live || !w_kill);
    assign w_bypass    = !w_kill && w_empty && w_load_ok;
    assign w_push      = w_load_ok && !w_bypass;

    always_comb begin
        w_pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_q_live[i]) begin
                w_pending[r_q_rd[i]] = 1'b1;
            end
        end
        w_pending[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head   <= '0;
            r_tail   <= '0;
            r_count  <= '0;
            r_q_live <= '0;
            r_we     <= 1'b0;
            r_wr     <= 5'd0;
            r_wd     <= 32'd0;
        end else begin
            // Kill, then pop, then push: later assignments win on overlap.
            r_q_live <= w_live_after;

            if (w_pop) begin
                r_q_live[r_head] <= 1'b0;
                r_head           <= (r_head == c_LAST) ? '0 : r_head + c_PTR_W'(1);
            end

            if (w_push) begin
                r_q_rd[r_tail]   <= bus.mem_rd;
                r_q_data[r_tail] <= bus.mem_data;
                r_q_live[r_tail] <= 1'b1;
                r_tail           <= (r_tail == c_LAST) ? '0 : r_tail + c_PTR_W'(1);
            end

            if (w_push && !w_pop) begin
                r_count <= r_count + c_ONE;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_ONE;
            end

            if (w_kill) begin
                r_we <= 1'b1;
                r_wr <= bus.alu_rd;
                r_wd <= bus.alu_data;
            end else if (w_head_live) begin
                r_we <= 1'b1;
                r_wr <= r_q_rd[r_head];
                r_wd <= r_q_data[r_head];
            end else if (w_bypass) begin
                r_we <= 1'b1;
                r_wr <= bus.mem_rd;
                r_wd <= bus.mem_data;
            end else begin
                r_we <= 1'b0;
            end
        end
    end

    assign bus.mem_ready     = w_mem_ready;
    assign bus.RegWrite      = r_we;
    assign bus.writeRegister = r_wr;
    assign bus.writeData     = r_wd;
    assign bus.pending       = w_pending;

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_write_arbiter
//  Description : Scoreboard bench for regfile_write_arbiter (DEPTH = 2).
//                Each expected register-file write is queued with the cycle
//                it must appear in; every cycle the write port is compared
//                against the scoreboard head.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_write_arbiter;

    logic clk;
    logic reset;

    regfile_write_arbiter_if bus ();

    regfile_write_arbiter #(.DEPTH(2)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int          due;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   n_cmp;
    int   n_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic expect_write(input int due, input logic [4:0] rd, input logic [31:0] data);
        exp_t e;
        e.due  = due;
        e.rd   = rd;
        e.data = data;
        sb.push_back(e);
    endtask

    // One clock edge, then compare the write port against the scoreboard.
    task automatic tick();
        logic we_exp;
        exp_t e;
        @(posedge clk);
        cyc++;
        #1;
        we_exp = (sb.size() > 0) && (sb[0].due == cyc);
        check("regwrite", {31'd0, bus.RegWrite}, {31'd0, we_exp});
        if (we_exp) begin
            e = sb.pop_front();
            check("write_reg",  {27'd0, bus.writeRegister}, {27'd0, e.rd});
            check("write_data", bus.writeData, e.data);
        end
    endtask

    task automatic drive_alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
        bus.alu_valid = v;
        bus.alu_rd    = rd;
        bus.alu_data  = d;
    endtask

    task automatic drive_mem(input logic v, input logic [4:0] rd, input logic [31:0] d);
        bus.mem_valid = v;
        bus.mem_rd    = rd;
        bus.mem_data  = d;
    endtask

    task automatic idle();
        drive_alu(1'b0, 5'd0, 32'd0);
        drive_mem(1'b0, 5'd0, 32'd0);
    endtask

    initial begin
        int a;
        cyc   = 0;
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        idle();

        // Reset then idle
        tick();
        check("rst_wreg",    {27'd0, bus.writeRegister}, 32'd0);
        check("rst_wdata",   bus.writeData, 32'd0);
        check("rst_pending", bus.pending, 32'd0);
        check("rst_ready",   {31'd0, bus.mem_ready}, 32'd0);
        tick();
        reset = 1'b0;
        #1;
        check("ready_after_rst", {31'd0, bus.mem_ready}, 32'd1);
        tick();
        check("pending_idle", bus.pending, 32'd0);

        // ALU latency of one
        drive_alu(1'b1, 5'd5, 32'h0000_1234);
        expect_write(cyc + 1, 5'd5, 32'h0000_1234);
        tick();
        idle();
        tick();

        // Bypass load
        drive_mem(1'b1, 5'd3, 32'hA5A5_A5A5);
        check("bypass_ready", {31'd0, bus.mem_ready}, 32'd1);
        expect_write(cyc + 1, 5'd3, 32'hA5A5_A5A5);
        tick();
        idle();
        tick();

        // Load to r0 accepted and discarded
        drive_mem(1'b1, 5'd0, 32'hDEAD_BEEF);
        check("r0_load_ready", {31'd0, bus.mem_ready}, 32'd1);
        tick();
        idle();
        check("r0_load_pending", bus.pending, 32'd0);

        // ALU to r0 is no request
        drive_alu(1'b1, 5'd0, 32'hCAFE_F00D);
        tick();
        idle();
        tick();

        // Priority and queueing: ALU burst while two loads arrive
        a = cyc + 1;
        expect_write(a,     5'd7, 32'h0000_0071);
        expect_write(a + 1, 5'd7, 32'h0000_0072);
        expect_write(a + 2, 5'd7, 32'h0000_0073);
        expect_write(a + 3, 5'd8, 32'h0000_0808);
        expect_write(a + 4, 5'd9, 32'h0000_0909);
        drive_alu(1'b1, 5'd7, 32'h0000_0071);
        drive_mem(1'b1, 5'd8, 32'h0000_0808);
        tick();
        check("pending_one", bus.pending, 32'h0000_0100);
        drive_alu(1'b1, 5'd7, 32'h0000_0072);
        drive_mem(1'b1, 5'd9, 32'h0000_0909);
        check("ready_one_queued", {31'd0, bus.mem_ready}, 32'd1);
        tick();
        drive_alu(1'b1, 5'd7, 32'h0000_0073);
        drive_mem(1'b1, 5'd10, 32'h0000_0A0A);
        check("pending_full", bus.pending, 32'h0000_0300);
        check("ready_full",   {31'd0, bus.mem_ready}, 32'd0);
        tick();
        idle();
        tick();
        check("pending_drain1", bus.pending, 32'h0000_0200);
        tick();
        check("pending_drain2", bus.pending, 32'd0);
        tick();

        // WAW cancel
        drive_alu(1'b1, 5'd1, 32'h0000_00AA);
        drive_mem(1'b1, 5'd4, 32'h0000_0044);
        expect_write(cyc + 1, 5'd1, 32'h0000_00AA);
        tick();
        check("waw_pending_set", bus.pending, 32'h0000_0010);
        drive_alu(1'b1, 5'd4, 32'h0000_0011);
        drive_mem(1'b0, 5'd0, 32'd0);
        expect_write(cyc + 1, 5'd4, 32'h0000_0011);
        tick();
        check("waw_pending_clr", bus.pending, 32'd0);
        idle();
        // Dead entry must be gone: a fresh load bypasses straight through.
        drive_mem(1'b1, 5'd12, 32'h0000_0C0C);
        expect_write(cyc + 1, 5'd12, 32'h0000_0C0C);
        tick();
        idle();
        tick();

        // Same-cycle conflict: load to the ALU's register is dropped
        drive_alu(1'b1, 5'd6, 32'h0000_0022);
        drive_mem(1'b1, 5'd6, 32'h0000_0033);
        check("conflict_ready", {31'd0, bus.mem_ready}, 32'd1);
        expect_write(cyc + 1, 5'd6, 32'h0000_0022);
        tick();
        idle();
        check("conflict_pending", bus.pending, 32'd0);
        tick();
        tick();

        // Mid-operation reset discards queued loads and the in-flight write
        drive_alu(1'b1, 5'd1, 32'h0000_0101);
        drive_mem(1'b1, 5'd13, 32'h0000_0D0D);
        expect_write(cyc + 1, 5'd1, 32'h0000_0101);
        tick();
        drive_alu(1'b1, 5'd1, 32'h0000_0102);
        drive_mem(1'b1, 5'd14, 32'h0000_0E0E);
        expect_write(cyc + 1, 5'd1, 32'h0000_0102);
        tick();
        check("pre_rst_pending", bus.pending, 32'h0000_6000);
        reset = 1'b1;
        drive_alu(1'b1, 5'd2, 32'h0000_0222);
        drive_mem(1'b0, 5'd0, 32'd0);
        #1;
        check("ready_in_rst", {31'd0, bus.mem_ready}, 32'd0);
        tick();
        check("mid_rst_pending", bus.pending, 32'd0);
        check("mid_rst_wreg", {27'd0, bus.writeRegister}, 32'd0);
        reset = 1'b0;
        idle();
        #1;
        check("mid_rst_ready", {31'd0, bus.mem_ready}, 32'd1);
        tick();
        tick();
        tick();
        check("final_pending", bus.pending, 32'd0);

        check("sb_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
